collatz_responder: RTL and testbench
====================================

COLLATZ_RESPONDER -- requirements
Module: collatz_responder

Interface
REQ-001 Parameter intN, default 27, SHALL set the operand/result datapath width in bits.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port nrst, input, 1: SHALL be the reset, asynchronous, active-low.
REQ-004 Port in_valid, input, 1: initiator SHALL assert it to offer in0.
REQ-005 Port in_ready, output, 1: high SHALL mean the block accepts in0 this cycle.
REQ-006 Port in0, input, intN: SHALL carry the starting value n.
REQ-007 Port out_valid, output, 1: high SHALL mean out0/out_ovf hold a result.
REQ-008 Port out_ready, input, 1: initiator SHALL assert it to consume the result.
REQ-009 Port out0, output, intN: SHALL carry the Collatz step count of n.
REQ-010 Port out_ovf, output, 1: high SHALL mean 3n+1 overflowed intN bits and out0 is invalid.

Function
REQ-011 Accept SHALL occur on a cycle where in_valid && in_ready; transfer out SHALL occur where out_valid && out_ready.
REQ-012 FSM SHALL have states IDLE, RUN, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 IDLE: on accept, if in0 <= 1, SHALL go to DONE with count 0 and ovf 0; else SHALL latch n=in0, count=0, go to RUN.
REQ-014 RUN: each cycle SHALL update n to n/2 if n even, 3n+1 if odd, and increment count by 1.
REQ-015 RUN SHALL go to DONE in the cycle the next n equals 1; that step SHALL be counted.
REQ-016 3n+1 SHALL be computed at intN+2 bits; any set bit above intN-1 SHALL set ovf and go to DONE, with count frozen.
REQ-017 count SHALL saturate at all-ones; saturation SHALL set ovf and go to DONE.
REQ-018 DONE: out0/out_ovf SHALL stay stable while out_valid is high and out_ready is low.
REQ-019 DONE: on transfer, SHALL return to IDLE; in_ready SHALL rise the following cycle. No same-cycle back-to-back accept is required.
REQ-020 Latency from accept to out_valid SHALL be exactly steps+1 cycles; for in0 <= 1 and overflow cases it SHALL be 1 cycle after accept/overflow detection.
REQ-021 in_valid and in0 SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-022 nrst low SHALL immediately force IDLE, in_ready=1 after deassert, out_valid=0, out0=0, out_ovf=0, n=0, count=0.
REQ-023 nrst asserted mid-RUN or mid-DONE SHALL discard the computation; no partial result SHALL ever appear.
REQ-024 Reset deassertion SHALL be treated as synchronous to clk by the instantiating top; the block SHALL add no synchronizer.

Structure
REQ-025 intN default, state encoding (IDLE=0, RUN=1, DONE=2), and the overflow guard width (intN+2) SHALL live in the shared primitives package.
REQ-026 One combinational sub-module collatz_step SHALL compute next n and an overflow flag from n; the FSM, counter and handshake SHALL stay in collatz_responder.
REQ-027 Port naming SHALL match the generated-module sync interface so the block drops into existing board tops in place of a generated tests_collatz instance.

Verification
REQ-028 in0=6, out_ready=1 -> out0=8, out_ovf=0, out_valid 9 cycles after accept.
REQ-029 in0=27 -> out0=111, out_ovf=0; in0=7 -> out0=16.
REQ-030 in0=1 and in0=0 -> out0=0, out_valid 1 cycle after accept.
REQ-031 Backpressure: in0=6, out_ready held low 5 cycles after out_valid -> out0=8 stable all 5 cycles; in_ready stays 0 until 1 cycle after transfer.
REQ-032 intN=8, in0=255 -> out_ovf=1 once 3n+1 exceeds 255, then IDLE after transfer.
REQ-033 in0=27, nrst pulsed low 20 cycles after accept -> out_valid=0 immediately; a subsequent in0=6 -> out0=8.

Source files
------------

// File: rtl/collatz_responder_pkg.sv
// collatz_responder_pkg: shared width defaults, FSM encoding and guard-width helper
package collatz_responder_pkg;
    localparam int INT_N      = 27;
    localparam int GUARD_BITS = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int guard_width(input int w);
        return w + GUARD_BITS;
    endfunction
endpackage

// File: rtl/collatz_step.sv
// collatz_step: one combinational Collatz step with 3n+1 overflow detection
module collatz_step
    import collatz_responder_pkg::*;
#(
    parameter int intN = INT_N
) (
    input  logic [intN-1:0] n,
    output logic [intN-1:0] n_next,
    output logic            ovf
);
    localparam int GW = guard_width(intN);
    logic [GW-1:0] tri_n;
    always_comb begin
        tri_n  = GW'(n) * GW'(3) + GW'(1);
        ovf    = n[0] && (|tri_n[GW-1:intN]);
        n_next = n[0] ? tri_n[intN-1:0] : n >> 1;
    end
endmodule

// File: rtl/collatz_responder.sv
// collatz_responder: ready/valid wrapper that counts Collatz steps from in0 down to 1
module collatz_responder
    import collatz_responder_pkg::*;
#(
    parameter int intN = INT_N
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [intN-1:0] in0,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [intN-1:0] out0,
    output logic            out_ovf
);
    state_t          state, state_nx;
    logic [intN-1:0] n, n_nx, cnt, cnt_nx, step_n;
    logic            ovf, ovf_nx, step_ovf;

    collatz_step #(.intN(intN)) u_step (
        .n      (n),
        .n_next (step_n),
        .ovf    (step_ovf)
    );

    always_comb begin
        state_nx = state;
        n_nx     = n;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        case (state)
            IDLE: if (in_valid) begin
                n_nx     = in0;
                cnt_nx   = '0;
                ovf_nx   = 1'b0;
                state_nx = (in0 <= intN'(1)) ? DONE : RUN;
            end
            RUN: if (step_ovf || (&cnt)) begin
                // overflow or saturated counter: freeze count and flag the result
                ovf_nx   = 1'b1;
                state_nx = DONE;
            end else begin
                n_nx     = step_n;
                cnt_nx   = cnt + intN'(1);
                state_nx = (step_n == intN'(1)) ? DONE : RUN;
            end
            DONE: state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            n     <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            n     <= n_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end

    // result is only visible in DONE so no partial count ever leaks out
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out0      = out_valid ? cnt : '0;
    assign out_ovf   = out_valid & ovf;
endmodule

// File: tb/tb_collatz_responder.sv
// tb_collatz_responder: randomized and directed checks against an arithmetic Collatz model
module tb_collatz_responder;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_ovf;
    logic [26:0] a_in0 = '0, a_out0;
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_ovf;
    logic [7:0]  b_in0 = '0, b_out0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    collatz_responder dut_a (
        .clk(clk), .nrst(nrst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in0(a_in0),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out0(a_out0), .out_ovf(a_out_ovf)
    );

    collatz_responder #(.intN(8)) dut_b (
        .clk(clk), .nrst(nrst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in0(b_in0),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out0(b_out0), .out_ovf(b_out_ovf)
    );

    // steps to reach 1, overflow when 3n+1 needs more than w bits, cycles from accept to out_valid
    function automatic void model(input longint n0, input int w, output longint steps,
                                  output bit ovf, output int lat);
        longint n = n0;
        steps = 0;
        ovf = 0;
        lat = 1;
        if (n <= 1) return;
        forever begin
            if (n % 2 == 1) begin
                if (3 * n + 1 >= (longint'(1) << w)) begin
                    ovf = 1;
                    lat = int'(steps) + 2;
                    return;
                end
                n = 3 * n + 1;
            end else n = n / 2;
            steps++;
            if (n == 1) begin
                lat = int'(steps) + 1;
                return;
            end
        end
    endfunction

    task automatic txn_a(input logic [26:0] v, input int hold, input bit noise,
                         output logic [26:0] res, output logic ovf_r, output int lat, output bit tmo);
        int g = 0;
        tmo = 0;
        while (!a_in_ready && g < 50) begin @(negedge clk); g++; end
        a_in_valid = 1'b1;
        a_in0 = v;
        @(negedge clk);
        lat = 1;
        a_in_valid = noise;
        a_out_ready = noise;
        while (!a_out_valid && lat < 3000) begin
            @(negedge clk);
            lat++;
            if (noise) begin a_in0 = 27'($urandom); a_out_ready = 1'($urandom); end
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        tmo = !a_out_valid;
        res = a_out0;
        ovf_r = a_out_ovf;
        if (tmo) return;
        repeat (hold) @(negedge clk);
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
    endtask

    task automatic txn_b(input logic [7:0] v, output logic [7:0] res, output logic ovf_r,
                         output int lat, output bit tmo);
        b_in_valid = 1'b1;
        b_in0 = v;
        @(negedge clk);
        lat = 1;
        b_in_valid = 1'b0;
        while (!b_out_valid && lat < 1000) begin @(negedge clk); lat++; end
        tmo = !b_out_valid;
        res = b_out0;
        ovf_r = b_out_ovf;
        if (tmo) return;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_out_valid, a_out_ovf, a_out0, b_out_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b ovf=%b out0=%0d b_valid=%b want all 0",
                     a_out_valid, a_out_ovf, a_out0, b_out_valid);
        end
        nrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got a=%b b=%b want 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_directed();
        logic [26:0] vals [5] = '{27'd6, 27'd27, 27'd7, 27'd1, 27'd0};
        logic [26:0] res;
        logic        o;
        int          lat;
        bit          tmo;
        longint      st;
        bit          eo;
        int          el;
        foreach (vals[i]) begin
            model(longint'(vals[i]), 27, st, eo, el);
            txn_a(vals[i], 0, 0, res, o, lat, tmo);
            n_checks++;
            if (tmo || res !== 27'(st) || o !== eo || lat != el) begin
                n_fail++;
                $display("FAIL directed n=%0d: got out0=%0d ovf=%b lat=%0d tmo=%b want out0=%0d ovf=%b lat=%0d",
                         vals[i], res, o, lat, tmo, st, eo, el);
            end
        end
    endtask

    task automatic test_backpressure();
        int g = 0;
        a_in_valid = 1'b1;
        a_in0 = 27'd6;
        @(negedge clk);
        a_in_valid = 1'b0;
        while (!a_out_valid && g < 100) begin @(negedge clk); g++; end
        repeat (5) begin
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out0 !== 27'd8 || a_out_ovf !== 1'b0 || a_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold: got valid=%b out0=%0d ovf=%b in_ready=%b want 1/8/0/0",
                         a_out_valid, a_out0, a_out_ovf, a_in_ready);
            end
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        n_checks++;
        if (a_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_xfer_cycle: got in_ready=%b want 0", a_in_ready);
        end
        @(negedge clk);
        a_out_ready = 1'b0;
        n_checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_after: got in_ready=%b valid=%b want 1/0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] res;
        logic       o;
        int         lat;
        bit         tmo;
        longint     st;
        bit         eo;
        int         el;
        txn_b(8'd255, res, o, lat, tmo);
        n_checks++;
        if (tmo || o !== 1'b1 || lat != 2) begin
            n_fail++;
            $display("FAIL ovf_255: got ovf=%b lat=%0d tmo=%b want ovf=1 lat=2", o, lat, tmo);
        end
        n_checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_idle: got in_ready=%b valid=%b want 1/0", b_in_ready, b_out_valid);
        end
        repeat (12) begin
            logic [7:0] v = 8'($urandom);
            model(longint'(v), 8, st, eo, el);
            txn_b(v, res, o, lat, tmo);
            n_checks++;
            if (tmo || o !== eo || lat != el || (!eo && res !== 8'(st))) begin
                n_fail++;
                $display("FAIL ovf_rand n=%0d: got out0=%0d ovf=%b lat=%0d want out0=%0d ovf=%b lat=%0d",
                         v, res, o, lat, st, eo, el);
            end
        end
    endtask

    task automatic test_random(input bit noise);
        logic [26:0] res;
        logic        o;
        int          lat;
        bit          tmo;
        longint      st;
        bit          eo;
        int          el;
        repeat (15) begin
            logic [26:0] v = 27'($urandom_range(0, 3000));
            model(longint'(v), 27, st, eo, el);
            txn_a(v, noise ? 0 : int'($urandom_range(0, 3)), noise, res, o, lat, tmo);
            n_checks++;
            if (tmo || res !== 27'(st) || o !== eo || lat != el) begin
                n_fail++;
                $display("FAIL random%s n=%0d: got out0=%0d ovf=%b lat=%0d want out0=%0d ovf=%b lat=%0d",
                         noise ? "_noise" : "", v, res, o, lat, st, eo, el);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [26:0] res;
        logic        o;
        int          lat;
        bit          tmo;
        a_in_valid = 1'b1;
        a_in0 = 27'd27;
        @(negedge clk);
        a_in_valid = 1'b0;
        repeat (19) @(negedge clk);
        n_checks++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_early: got valid=%b want 0", a_out_valid);
        end
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out0 !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got valid=%b in_ready=%b out0=%0d want 0/1/0",
                     a_out_valid, a_in_ready, a_out0);
        end
        @(negedge clk);
        nrst = 1'b1;
        txn_a(27'd6, 0, 0, res, o, lat, tmo);
        n_checks++;
        if (tmo || res !== 27'd8 || o !== 1'b0 || lat != 9) begin
            n_fail++;
            $display("FAIL after_reset: got out0=%0d ovf=%b lat=%0d want 8/0/9", res, o, lat);
        end
        a_in_valid = 1'b1;
        a_in0 = 27'd1;
        @(negedge clk);
        a_in_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL done_reset: got valid=%b ovf=%b want 0/0", a_out_valid, a_out_ovf);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_overflow();
        test_random(0);
        test_random(1);
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
